// File: rtl/mem_responder_if.sv
// mem_responder_if: processor memory port between the memory arbiter
// (master) and the memory responder (slave). Command, address and store
// data flow toward memory; the acceptance tag and tagged load responses
// flow back.
interface mem_responder_if;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_transaction_tag;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_data_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: tagged main-memory model. Accepts one load/store per cycle,
// hands back a tag (1..15) combinationally, and returns each transaction's
// data MEM_LATENCY cycles later on registered outputs.
// Optional build macro MEM_RANDOM_STALL_EN adds an 8-bit LFSR that randomly
// rejects commands to exercise initiator retry.
module mem_responder #(
  parameter int MEM_LATENCY = 10,
  parameter int MEM_DEPTH   = 8192
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int          IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH) * 33'd8;
  localparam logic [5:0]  CNT_INIT   = 6'(MEM_LATENCY - 1);
  localparam logic [1:0]  CMD_LOAD   = 2'd1;
  localparam logic [1:0]  CMD_STORE  = 2'd2;

  // Backing store; deliberately not reset so contents survive a reset.
  logic [63:0] mem_q [MEM_DEPTH];

  // Tag table, one entry per tag 1..15.
  logic [15:1] valid_q, valid_d;
  logic [5:0]  cnt_q   [1:15];
  logic [5:0]  cnt_d   [1:15];
  logic [63:0] dbuf_q  [1:15];
  logic [63:0] dbuf_d  [1:15];

  logic [3:0]  rsp_tag_q, rsp_tag_d;
  logic [63:0] rsp_data_q, rsp_data_d;

  logic [3:0]       alloc_tag;
  logic             is_cmd;
  logic             addr_ok;
  logic             stall;
  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [63:0]      rd_data;

`ifdef MEM_RANDOM_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // LFSR next state, taps for x^8+x^6+x^5+x^4+1.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register, reseeded on reset, free-running otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= 8'h5A;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign idx     = bus.proc2mem_addr[3 +: IDX_W];
  assign rd_data = mem_q[idx];
  assign is_cmd  = (bus.proc2mem_command == CMD_LOAD) || (bus.proc2mem_command == CMD_STORE);
  assign addr_ok = ({1'b0, bus.proc2mem_addr} < ADDR_LIMIT);

  // Lowest-numbered tag not currently held; a tag still responding this
  // cycle is valid and therefore never chosen.
  always_comb begin
    alloc_tag = 4'd0;
    for (int i = 15; i >= 1; i--) begin
      alloc_tag = valid_q[i] ? alloc_tag : 4'(i);
    end
  end

  assign accept = !reset && is_cmd && addr_ok && (alloc_tag != 4'd0) && !stall;
  assign bus.mem2proc_transaction_tag = accept ? alloc_tag : 4'd0;

  // Tag-table next state and selection of the entry to present next cycle.
  always_comb begin
    valid_d    = valid_q;
    rsp_tag_d  = 4'd0;
    rsp_data_d = 64'd0;
    for (int i = 1; i <= 15; i++) begin
      cnt_d[i]   = (valid_q[i] && (cnt_q[i] != 6'd0)) ? (cnt_q[i] - 6'd1) : cnt_q[i];
      dbuf_d[i]  = dbuf_q[i];
      // The entry currently on the response outputs retires at this edge.
      valid_d[i] = valid_q[i] && (rsp_tag_q != 4'(i));
      if (accept && (alloc_tag == 4'(i))) begin
        valid_d[i] = 1'b1;
        cnt_d[i]   = CNT_INIT;
        dbuf_d[i]  = (bus.proc2mem_command == CMD_STORE) ? 64'd0 : rd_data;
      end else begin
        dbuf_d[i]  = dbuf_d[i];
      end
    end
    // Lowest-numbered due entry wins; others hold at zero and wait.
    for (int i = 15; i >= 1; i--) begin
      if (valid_d[i] && (cnt_d[i] == 6'd0)) begin
        rsp_tag_d  = 4'(i);
        rsp_data_d = dbuf_d[i];
      end else begin
        rsp_tag_d  = rsp_tag_d;
      end
    end
  end

  // Tag table and registered response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      rsp_tag_q  <= 4'd0;
      rsp_data_q <= 64'd0;
      for (int i = 1; i <= 15; i++) begin
        cnt_q[i]  <= 6'd0;
        dbuf_q[i] <= 64'd0;
      end
    end else begin
      valid_q    <= valid_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_data_q <= rsp_data_d;
      for (int i = 1; i <= 15; i++) begin
        cnt_q[i]  <= cnt_d[i];
        dbuf_q[i] <= dbuf_d[i];
      end
    end
  end

  // Store write at the acceptance edge, so a load in the next cycle sees it.
  always_ff @(posedge clock) begin
    if (accept && (bus.proc2mem_command == CMD_STORE)) begin
      mem_q[idx] <= bus.proc2mem_data;
    end
  end

  assign bus.mem2proc_data_tag = rsp_tag_q;
  assign bus.mem2proc_data     = rsp_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder. DUT A (latency 10)
// carries the main scenarios, DUT B (latency 1) the back-to-back case and
// DUT C (latency 20) the table-full case.
module tb_mem_responder;

  localparam int          LAT_A   = 10;
  localparam logic [32:0] LIMIT_A = 33'd65536;
  localparam logic [1:0]  C_NONE  = 2'd0;
  localparam logic [1:0]  C_LOAD  = 2'd1;
  localparam logic [1:0]  C_STORE = 2'd2;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] data;
    int          due;
  } exp_t;

  logic clock;
  logic reset;

  int errors;
  int checks;
  int cyc;
  logic [15:1] busy;
  logic [7:0]  m_lfsr;
  exp_t        sbq[$];
  logic [63:0] mmem [int];

  mem_responder_if bus_a();
  mem_responder_if bus_b();
  mem_responder_if bus_c();

  mem_responder #(.MEM_LATENCY(LAT_A), .MEM_DEPTH(8192)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  mem_responder #(.MEM_LATENCY(1),     .MEM_DEPTH(8192)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));
  mem_responder #(.MEM_LATENCY(20),    .MEM_DEPTH(8192)) dut_c (.clock(clock), .reset(reset), .bus(bus_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One cycle on DUT A: drive, sample at negedge, check against the model.
  task automatic step(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] wdata,
                      input logic rst, output logic [3:0] tag_o, output logic [3:0] rtag_o,
                      output logic [63:0] rdata_o);
    logic [3:0] exp_tag;
    logic       stall_m;
    exp_t       e;
    int         idx;
    @(posedge clock);
    #1;
    reset = rst;
    bus_a.proc2mem_command = cmd;
    bus_a.proc2mem_addr    = addr;
    bus_a.proc2mem_data    = wdata;
    @(negedge clock);
    tag_o   = bus_a.mem2proc_transaction_tag;
    rtag_o  = bus_a.mem2proc_data_tag;
    rdata_o = bus_a.mem2proc_data;
`ifdef MEM_RANDOM_STALL_EN
    stall_m = (m_lfsr[1:0] == 2'b00);
`else
    stall_m = 1'b0;
`endif
    exp_tag = 4'd0;
    if (!rst && (cmd == C_LOAD || cmd == C_STORE) && ({1'b0, addr} < LIMIT_A) && !stall_m) begin
      for (int t = 15; t >= 1; t--) if (!busy[t]) exp_tag = 4'(t);
    end
    checks++;
    if (tag_o !== exp_tag) begin
      errors++;
      $display("FAIL txn_tag cycle %0d: got %0d expected %0d", cyc, tag_o, exp_tag);
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
    end else begin
      e.tag = 4'd0; e.data = 64'd0; e.due = cyc;
    end
    checks++;
    if (rtag_o !== e.tag || rdata_o !== e.data) begin
      errors++;
      $display("FAIL response cycle %0d: got tag %0d data %h expected tag %0d data %h",
               cyc, rtag_o, rdata_o, e.tag, e.data);
    end
    if (e.tag != 4'd0) busy[e.tag] = 1'b0;
    if (exp_tag != 4'd0) begin
      busy[exp_tag] = 1'b1;
      idx = int'(addr[15:3]);
      e.tag = exp_tag;
      e.due = cyc + LAT_A;
      if (cmd == C_STORE) begin
        mmem[idx] = wdata;
        e.data = 64'd0;
      end else begin
        e.data = mmem[idx];
      end
      sbq.push_back(e);
    end
    if (rst) begin
      sbq.delete();
      busy   = '0;
      m_lfsr = 8'h5A;
    end else begin
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    logic [3:0] t, rt; logic [63:0] rd;
    for (int k = 0; k < n; k++) step(C_NONE, 32'd0, 64'd0, 1'b0, t, rt, rd);
  endtask

  task automatic issue_retry(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] wdata);
    logic [3:0] t, rt; logic [63:0] rd; int tries;
    t = 4'd0; tries = 0;
    while (t == 4'd0 && tries < 64) begin
      step(cmd, addr, wdata, 1'b0, t, rt, rd);
      tries++;
    end
    checks++;
    if (t == 4'd0) begin
      errors++;
      $display("FAIL retry_bound addr %h: got tag %0d after %0d tries, required nonzero", addr, t, tries);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.proc2mem_command = C_LOAD; bus_a.proc2mem_addr = 32'h20; bus_a.proc2mem_data = 64'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus_a.mem2proc_data_tag !== 4'd0 || bus_a.mem2proc_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: got tag %0d data %h expected 0 and 0",
               bus_a.mem2proc_data_tag, bus_a.mem2proc_data);
    end
    checks++;
    if (bus_a.mem2proc_transaction_tag !== 4'd0) begin
      errors++;
      $display("FAIL reset_txn_tag: got %0d expected 0", bus_a.mem2proc_transaction_tag);
    end
    busy = '0; sbq.delete(); m_lfsr = 8'h5A; cyc = 0;
  endtask

  task automatic test_basic_load();
    logic [3:0] t, rt; logic [63:0] rd;
    step(C_STORE, 32'h20, 64'hDEAD_BEEF_0000_0004, 1'b0, t, rt, rd);
    idle(LAT_A + 2);
    step(C_LOAD, 32'h20, 64'd0, 1'b0, t, rt, rd);
    checks++;
    if (t !== 4'd1) begin errors++; $display("FAIL basic_tag: got %0d expected 1", t); end
    for (int k = 1; k <= 11; k++) begin
      step(C_NONE, 32'd0, 64'd0, 1'b0, t, rt, rd);
      checks++;
      if (k == 10) begin
        if (rt !== 4'd1 || rd !== 64'hDEAD_BEEF_0000_0004) begin
          errors++; $display("FAIL basic_resp: got tag %0d data %h expected 1 deadbeef00000004", rt, rd);
        end
      end else if (rt !== 4'd0) begin
        errors++; $display("FAIL basic_quiet cycle %0d: got tag %0d expected 0", k, rt);
      end
    end
  endtask

  task automatic test_store_load();
    logic [3:0] t, rt; logic [63:0] rd;
    step(C_STORE, 32'h40, 64'h1234, 1'b0, t, rt, rd);
    checks++;
    if (t !== 4'd1) begin errors++; $display("FAIL st_tag: got %0d expected 1", t); end
    step(C_LOAD, 32'h40, 64'd0, 1'b0, t, rt, rd);
    checks++;
    if (t !== 4'd2) begin errors++; $display("FAIL ld_tag: got %0d expected 2", t); end
    for (int k = 2; k <= 12; k++) begin
      step(C_NONE, 32'd0, 64'd0, 1'b0, t, rt, rd);
      if (k == 10) begin
        checks++;
        if (rt !== 4'd1 || rd !== 64'd0) begin
          errors++; $display("FAIL st_resp: got tag %0d data %h expected 1 0", rt, rd);
        end
      end else if (k == 11) begin
        checks++;
        if (rt !== 4'd2 || rd !== 64'h1234) begin
          errors++; $display("FAIL ld_after_st: got tag %0d data %h expected 2 1234", rt, rd);
        end
      end
    end
  endtask

  task automatic test_addr_range();
    logic [3:0] t, rt; logic [63:0] rd;
    step(C_LOAD, 32'h0001_0000, 64'd0, 1'b0, t, rt, rd);
    checks++;
    if (t !== 4'd0) begin errors++; $display("FAIL addr_over: got %0d expected 0", t); end
    step(C_STORE, 32'h0000_FFF8, 64'hA5, 1'b0, t, rt, rd);
    checks++;
    if (t !== 4'd1) begin errors++; $display("FAIL addr_last: got %0d expected 1", t); end
    step(2'd3, 32'h20, 64'd0, 1'b0, t, rt, rd);
    checks++;
    if (t !== 4'd0) begin errors++; $display("FAIL cmd3: got %0d expected 0", t); end
    idle(LAT_A + 4);
  endtask

  task automatic test_reset_mid();
    logic [3:0] t, rt; logic [63:0] rd;
    for (int k = 0; k < 3; k++) begin
      step(C_LOAD, 32'h20, 64'd0, 1'b0, t, rt, rd);
      checks++;
      if (t !== 4'(k + 1)) begin errors++; $display("FAIL pre_reset_tag %0d: got %0d expected %0d", k, t, k + 1); end
    end
    idle(2);
    step(C_NONE, 32'd0, 64'd0, 1'b1, t, rt, rd);
    for (int k = 0; k < 15; k++) begin
      step(C_NONE, 32'd0, 64'd0, 1'b0, t, rt, rd);
      checks++;
      if (rt !== 4'd0) begin errors++; $display("FAIL post_reset_pulse %0d: got tag %0d expected 0", k, rt); end
    end
    step(C_LOAD, 32'h20, 64'd0, 1'b0, t, rt, rd);
    checks++;
    if (t !== 4'd1) begin errors++; $display("FAIL post_reset_tag: got %0d expected 1", t); end
    idle(LAT_A + 2);
  endtask

  task automatic test_random();
    for (int b = 0; b < 16; b++) issue_retry(C_STORE, 32'((100 + b) * 8), {$urandom(), $urandom()});
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue_retry(C_LOAD, 32'((100 + $urandom_range(0, 15)) * 8), 64'd0);
    end
    idle(LAT_A + 4);
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL random_drain: got %0d pending expected 0", sbq.size()); end
  endtask

  task automatic test_latency_one();
    logic [3:0]  prev_tag, exp_tag, t;
    logic [63:0] prev_data, cur_data;
    prev_tag = 4'd0; prev_data = 64'd0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock); #1;
      bus_b.proc2mem_command = (i < 4) ? C_STORE : ((i < 8) ? C_LOAD : C_NONE);
      bus_b.proc2mem_addr    = 32'((i % 4) * 8);
      bus_b.proc2mem_data    = 64'hB000_0000_0000_0000 | 64'(i);
      @(negedge clock);
      t = bus_b.mem2proc_transaction_tag;
      exp_tag  = (i == 8) ? 4'd0 : ((prev_tag == 4'd1) ? 4'd2 : 4'd1);
      cur_data = (i < 4) ? 64'd0 : (64'hB000_0000_0000_0000 | 64'(i - 4));
      checks++;
      if (t !== exp_tag) begin errors++; $display("FAIL lat1_tag %0d: got %0d expected %0d", i, t, exp_tag); end
      checks++;
      if (bus_b.mem2proc_data_tag !== prev_tag || bus_b.mem2proc_data !== prev_data) begin
        errors++;
        $display("FAIL lat1_resp %0d: got tag %0d data %h expected %0d %h", i,
                 bus_b.mem2proc_data_tag, bus_b.mem2proc_data, prev_tag, prev_data);
      end
      prev_tag  = exp_tag;
      prev_data = (exp_tag == 4'd0) ? 64'd0 : cur_data;
    end
    bus_b.proc2mem_command = C_NONE;
  endtask

  task automatic test_full();
    logic [3:0] t; int acc_cycle; logic [3:0] acc_tag;
    acc_cycle = -1; acc_tag = 4'd0;
    for (int c = 0; c < 40 && acc_cycle < 0; c++) begin
      @(posedge clock); #1;
      bus_c.proc2mem_command = C_LOAD; bus_c.proc2mem_addr = 32'h20; bus_c.proc2mem_data = 64'd0;
      @(negedge clock);
      t = bus_c.mem2proc_transaction_tag;
      if (c < 15) begin
        checks++;
        if (t !== 4'(c + 1)) begin errors++; $display("FAIL full_tag %0d: got %0d expected %0d", c, t, c + 1); end
      end else if (t !== 4'd0) begin
        acc_cycle = c; acc_tag = t;
      end
      if (c == 20) begin
        checks++;
        if (bus_c.mem2proc_data_tag !== 4'd1) begin
          errors++; $display("FAIL full_first_resp: got tag %0d expected 1", bus_c.mem2proc_data_tag);
        end
      end
    end
    bus_c.proc2mem_command = C_NONE;
    checks++;
    if (acc_cycle != 21 || acc_tag !== 4'd1) begin
      errors++; $display("FAIL full_retry: got cycle %0d tag %0d expected cycle 21 tag 1", acc_cycle, acc_tag);
    end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; busy = '0; m_lfsr = 8'h5A;
    bus_b.proc2mem_command = C_NONE; bus_b.proc2mem_addr = 32'd0; bus_b.proc2mem_data = 64'd0;
    bus_c.proc2mem_command = C_NONE; bus_c.proc2mem_addr = 32'd0; bus_c.proc2mem_data = 64'd0;
    test_reset();
`ifndef MEM_RANDOM_STALL_EN
    test_basic_load();
    test_store_load();
    test_addr_range();
    test_reset_mid();
    test_latency_one();
    test_full();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
